// File: rtl/gcd_result_fifo.sv
// gcd_result_fifo: FWFT result buffer for the GCD pipeline with sticky overflow flag.
// Optional saturating drop counter enabled by GCD_RESULT_FIFO_DROPCNT_EN.
module gcd_result_fifo #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int DROP_CNT_WIDTH = 16,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             Done,
  input  logic signed [DATA_WIDTH-1:0]     Result,
  output logic                             OutValid,
  input  logic                             OutReady,
  output logic signed [DATA_WIDTH-1:0]     OutData,
  output logic        [CW-1:0]             Count,
  output logic                             Full,
  output logic                             Empty,
  output logic                             Overflow,
  input  logic                             ClrOverflow,
  output logic        [DROP_CNT_WIDTH-1:0] DropCount
);
  logic signed [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_push, w_pop, w_drop;
  always_comb begin
    Count    = r_count;
    Full     = r_count == CW'(FIFO_DEPTH);
    Empty    = r_count == '0;
    OutValid = !Empty;
    OutData  = r_mem[r_rd_ptr];
    Overflow = r_overflow;
    w_pop    = OutValid && OutReady;
    w_push   = Done && (!Full || w_pop);
    w_drop   = Done && Full && !w_pop;
  end
  // Storage has no reset: contents are unreachable until rewritten.
  always_ff @(posedge Clk)
    if (!Reset && w_push) r_mem[r_wr_ptr] <= Result;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_overflow <= w_drop ? 1'b1 : ClrOverflow ? 1'b0 : r_overflow;
    end
  end
`ifdef GCD_RESULT_FIFO_DROPCNT_EN
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
  // A clear coinciding with a drop restarts the count at that drop.
  always_ff @(posedge Clk) begin
    if (Reset) r_drop_cnt <= '0;
    else if (ClrOverflow) r_drop_cnt <= DROP_CNT_WIDTH'(w_drop);
    else if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
  end
  assign DropCount = r_drop_cnt;
`else
  assign DropCount = '0;
`endif
endmodule

// File: tb/tb_gcd_result_fifo.sv
// tb_gcd_result_fifo: table-driven directed check of gcd_result_fifo, plus hand sequences.
module tb_gcd_result_fifo;
`ifdef GCD_RESULT_FIFO_DROPCNT_EN
  localparam int DC_EN = 1;
`else
  localparam int DC_EN = 0;
`endif
  logic        Clk, Reset, Done, OutReady, ClrOverflow;
  logic signed [31:0] Result, OutData;
  logic        OutValid, Full, Empty, Overflow;
  logic [3:0]  Count;
  logic [15:0] DropCount;
  int n_checks = 0, n_errors = 0;
  gcd_result_fifo dut (
    .Clk(Clk), .Reset(Reset), .Done(Done), .Result(Result),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .Count(Count), .Full(Full), .Empty(Empty), .Overflow(Overflow),
    .ClrOverflow(ClrOverflow), .DropCount(DropCount)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  typedef struct {
    bit rst, done, rdy, clr;
    int res;
    bit ev;
    int ed, ec;
    bit eo;
    int edc;
  } vec_t;
  vec_t vecs[$];
  function automatic void add(bit rst, bit done, int res, bit rdy, bit clr,
                              bit ev, int ed, int ec, bit eo, int edc);
    vec_t v;
    v.rst = rst; v.done = done; v.res = res; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo; v.edc = edc * DC_EN;
    vecs.push_back(v);
  endfunction
  task automatic chk(string name, int row, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask
  task automatic drive(bit rst, bit done, int res, bit rdy, bit clr);
    Reset = rst; Done = done; Result = res; OutReady = rdy; ClrOverflow = clr;
  endtask
  initial begin
    int first;
    drive(1, 0, 0, 0, 0);
    // reset, single result, empty-ready ignored
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 21, 0, 0, 1, 21, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 21, 1, 0, 0);
    add(0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    // empty with Done+OutReady: push only
    add(0, 1, 7, 1, 0,  1, 7, 1, 0, 0);
    add(0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    // fill 1..8, then push 9 while popping at full
    for (int i = 1; i <= 8; i++) add(0, 1, i, 0, 0, 1, 1, i, 0, 0);
    add(0, 1, 9, 1, 0,  1, 2, 8, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 0, 0, 1, 0, k < 8, 2 + k, 8 - k, 0, 0);
    // refill 11..18, drops, clear-vs-drop priority, then drain
    for (int i = 1; i <= 8; i++) add(0, 1, 10 + i, 0, 0, 1, 11, i, 0, 0);
    add(0, 1, 99, 0, 0, 1, 11, 8, 1, 1);
    add(0, 1, 98, 0, 0, 1, 11, 8, 1, 2);
    add(0, 1, 97, 0, 1, 1, 11, 8, 1, 1);
    add(0, 0, 0, 0, 1,  1, 11, 8, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 0, 0, 1, 0, k < 8, 11 + k, 8 - k, 0, 0);
    // wrap-around streaming 100..131
    for (int i = 0; i < 32; i++) add(0, 1, 100 + i, 1, 0, 1, 100 + i, 1, 0, 0);
    add(0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    // reset mid-operation with overflow set and Done presented
    for (int i = 1; i <= 8; i++) add(0, 1, 199 + i, 0, 0, 1, 200, i, 0, 0);
    add(0, 1, 55, 0, 0, 1, 200, 8, 1, 1);
    add(1, 1, 77, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 5, 0, 0,  1, 5, 1, 0, 0);
    add(0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    for (int r = 0; r < vecs.size(); r++) begin
      drive(vecs[r].rst, vecs[r].done, vecs[r].res, vecs[r].rdy, vecs[r].clr);
      @(posedge Clk);
      #1;
      chk("OutValid", r, int'(OutValid), int'(vecs[r].ev));
      chk("Count", r, int'(Count), vecs[r].ec);
      chk("Full", r, int'(Full), int'(vecs[r].ec == 8));
      chk("Empty", r, int'(Empty), int'(vecs[r].ec == 0));
      chk("Overflow", r, int'(Overflow), int'(vecs[r].eo));
      chk("DropCount", r, int'(DropCount), vecs[r].edc);
      if (vecs[r].ev) chk("OutData", r, int'(OutData), vecs[r].ed);
    end
    // hand sequence: no combinational bypass, bounded wait, stable head, signed data
    drive(0, 1, -12, 0, 0);
    #1;
    chk("no_bypass", -1, int'(OutValid), 0);
    first = -1;
    for (int c = 0; c < 4 && first < 0; c++) begin
      @(posedge Clk);
      #1;
      Done = 0;
      if (OutValid) first = c;
    end
    chk("latency", -1, first, 0);
    drive(0, 1, -34, 0, 0);
    @(posedge Clk);
    #1;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge Clk);
    #1;
    chk("stable_head", -1, int'(OutData), -12);
    chk("stable_count", -1, int'(Count), 2);
    OutReady = 1;
    @(posedge Clk);
    #1;
    chk("second_word", -1, int'(OutData), -34);
    @(posedge Clk);
    #1;
    chk("drained", -1, int'(Empty), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/gcd_result_fifo.md
Name: gcd_result_fifo

Overview:
Downstream result buffer for the GCD pipeline. It captures each Result word on the cycle the pipeline's Done strobe is high. Results are held in a first-word-fall-through FIFO and presented to the consumer over a valid/ready handshake. The GCD pipeline cannot be stalled, so this block reports any dropped result through a sticky overflow flag.

Parameters:
DATA_WIDTH, 32, width of the signed Result word; must match the pipeline's DATA_WIDTH
FIFO_DEPTH, 8, number of entries; power of two, >= 2
DROP_CNT_WIDTH, 16, width of the optional drop counter

Ports:
Clk  input  1  rising-edge clock, shared with the GCD pipeline
Reset  input  1  synchronous reset, active-high
Done  input  1  result-valid strobe from the GCD pipeline output stage
Result  input  DATA_WIDTH  signed GCD result, valid when Done=1
OutValid  output  1  OutData holds a valid entry (equals !Empty)
OutReady  input  1  consumer accepts OutData this cycle
OutData  output  DATA_WIDTH  head-of-FIFO word, signed, unmodified
Count  output  $clog2(FIFO_DEPTH+1)  current occupancy, registered
Full  output  1  Count == FIFO_DEPTH
Empty  output  1  Count == 0
Overflow  output  1  sticky flag: at least one result was dropped
ClrOverflow  input  1  clears Overflow (one-cycle pulse)
DropCount  output  DROP_CNT_WIDTH  saturating count of dropped results (optional feature)

Behaviour:
- Reset (sampled on Clk edge, Reset=1) clears write/read pointers, Count, Overflow and DropCount. Stored contents are discarded.
- Values after reset: OutValid=0, Empty=1, Full=0, Count=0, Overflow=0, DropCount=0. OutData is don't-care while OutValid=0.
- Reset mid-operation: all in-flight entries are lost. Done and OutReady are ignored in the reset cycle.
- Push condition: push = Done && (!Full || pop).
- Pop condition: pop = OutValid && OutReady.
- Push writes Result to mem[wr_ptr] and increments wr_ptr.
- Pop increments rd_ptr.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0.
- Count update: +1 on push only, -1 on pop only, unchanged when push and pop occur together or neither occurs.
- Latency: Done at cycle n into an empty FIFO gives OutValid=1 with OutData=Result at cycle n+1. There is no combinational bypass.
- First-word-fall-through: OutData = mem[rd_ptr] whenever OutValid=1. OutData is stable until popped.
- Full and simultaneous Done+pop: push is accepted and nothing is dropped; Count stays FIFO_DEPTH.
- Empty and simultaneous Done+OutReady: only the push occurs (OutValid=0, so no pop); Count goes 0 -> 1.
- Drop: Done && Full && !pop. The Result word is discarded and the FIFO is unchanged. Overflow=1 from the next cycle.
- Overflow is cleared by ClrOverflow=1. If a drop and ClrOverflow occur in the same cycle, the set wins and Overflow stays 1.
- OutReady while OutValid=0 is ignored.
- Data is passed bit-exact; there is no sign manipulation or width change.
- Full, Empty and OutValid are derived from the registered Count, so they are glitch-free.

Optional Feature:
Macro GCD_RESULT_FIFO_DROPCNT_EN.
- Defined: DropCount increments by 1 on every drop and saturates at 2^DROP_CNT_WIDTH-1.
  - Cleared by Reset and by ClrOverflow.
  - If a drop and ClrOverflow occur in the same cycle, DropCount becomes 1.
- Undefined: DropCount is tied to 0 and no counter logic is present. The port still exists.

Test Plan:
- Single result: Reset, then Done=1 with Result=21 for one cycle, OutReady=0 -> next cycle OutValid=1, OutData=21, Count=1. Raise OutReady -> Empty=1 the following cycle.
- Fill and order: FIFO_DEPTH=8, push Results 1..8 on consecutive cycles with OutReady=0 -> Full=1, Count=8, Overflow=0. Then hold OutReady=1 -> OutData reads 1..8 in order, then Empty=1.
- Overflow: FIFO full, Done with Result=99, OutReady=0 -> 99 is never output and Overflow=1. Next Done gives DropCount=2 when the macro is defined, 0 when undefined. ClrOverflow pulse -> Overflow=0 and DropCount=0.
- Full with simultaneous push/pop: FIFO full holding 1..8, Done with Result=9 and OutReady=1 in the same cycle -> Count stays 8, Overflow stays 0, output sequence is 2..9.
- Wrap-around streaming: Done every cycle with Results 100..131 and OutReady=1 every cycle -> all 32 values emerge in order, Count toggles between 0 and 1 only, Overflow=0.
- Reset mid-operation: 5 entries stored, assert Reset for one cycle while Done=1 -> next cycle Count=0, OutValid=0, Overflow=0, and the word presented with Done is not stored.
